// File: rtl/dpr_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dpr_port_arbiter_if
// One requester channel into the dual-port RAM port arbiter.
//   valid  : requester wants an access this cycle (held until accepted)
//   ready  : arbiter grants this requester in the current cycle (combinational)
//   we     : 1 = write, 0 = read
//   addr   : RAM word address
//   data   : write data
//   rvalid : read data valid (one cycle, the cycle after a read accept)
//   rdata  : read data
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dpr_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output valid, we, addr, data,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, we, addr, data,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/dpr_port_arbiter.sv
// -----------------------------------------------------------------------------
// dpr_port_arbiter
// Shares one port of a true dual-port RAM between two requesters. Round-robin
// arbitration with a bounded burst hold: the current holder keeps the port for
// up to MAX_BURST consecutive grants while the other side waits. One RAM access
// per cycle; each read result is routed back to the requester that issued it.
//
// Ports
//   clk       clock (the RAM port is clocked from the same net)
//   rst       asynchronous active-high reset
//   r0, r1    requester channels (dpr_port_arbiter_if.slave)
//   ram_addr  RAM port address   (granted requester's addr, 0 when idle)
//   ram_data  RAM port data      (granted requester's data, 0 when idle)
//   ram_we    RAM port write enable (accept & we)
//   ram_q     RAM port registered read data (1-cycle latency, write-first)
// -----------------------------------------------------------------------------
module dpr_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dpr_port_arbiter_if.slave     r0,
    dpr_port_arbiter_if.slave     r1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;    // grants in the current tenure
    logic             last_reg;   // requester granted most recently
    logic [1:0]       pend_reg;   // one-hot: read issued last cycle, per requester

    logic grant0;
    logic grant1;
    logic below_max;

    assign below_max = (cnt_reg < CNT_MAX);

    // Grant decision. The holder keeps the port until its burst budget is
    // spent, but only if the other side is actually waiting; a sole requester
    // is never stalled. Grants are forced low while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    grant0 = r0.valid & (~r1.valid | last_reg);
                    grant1 = r1.valid & (~r0.valid | ~last_reg);
                end
                HOLD0: begin
                    grant0 = r0.valid & (below_max | ~r1.valid);
                    grant1 = r1.valid & ~grant0;
                end
                HOLD1: begin
                    grant1 = r1.valid & (below_max | ~r0.valid);
                    grant0 = r0.valid & ~grant1;
                end
                default: begin
                    grant0 = 1'b0;
                    grant1 = 1'b0;
                end
            endcase
        end
    end

    assign r0.ready = grant0;
    assign r1.ready = grant1;

    // RAM drive: straight mux of the granted requester; the RAM samples it
    // at the same edge that completes the handshake.
    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_we   = 1'b0;
        if (grant0) begin
            ram_addr = r0.addr;
            ram_data = r0.data;
            ram_we   = r0.we;
        end else if (grant1) begin
            ram_addr = r1.addr;
            ram_data = r1.data;
            ram_we   = r1.we;
        end
    end

    // Arbitration state and read-return tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= 1'b1;
            pend_reg  <= 2'b00;
        end else begin
            // A read accepted now returns data from the RAM next cycle.
            pend_reg <= {grant1 & ~r1.we, grant0 & ~r0.we};

            if (grant0) begin
                last_reg <= 1'b0;
                if (state_reg == HOLD0) begin
                    if (below_max) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end else begin
                    state_reg <= HOLD0;
                    cnt_reg   <= CNT_ONE;
                end
            end else if (grant1) begin
                last_reg <= 1'b1;
                if (state_reg == HOLD1) begin
                    if (below_max) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end else begin
                    state_reg <= HOLD1;
                    cnt_reg   <= CNT_ONE;
                end
            end else begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
            end
        end
    end

    // Both requesters see the shared RAM output; rvalid says whose it is.
    assign r0.rvalid = pend_reg[0];
    assign r1.rvalid = pend_reg[1];
    assign r0.rdata  = ram_q;
    assign r1.rdata  = ram_q;

endmodule

// File: tb/tb_dpr_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dpr_port_arbiter
// Drives two requesters into the arbiter with a behavioural RAM on the shared
// port. A reference model (tenure holder, run length, last winner, shadow
// memory) predicts grants, RAM drive and read returns every cycle; directed
// scenarios add literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_dpr_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    dpr_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r0_bus ();
    dpr_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) r1_bus ();

    dpr_port_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .r0       (r0_bus),
        .r1       (r1_bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .ram_q    (ram_q)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 7 + 3);
    endfunction

    // ---------------- behavioural RAM (write-first, registered q) -----------
    logic          init_phase;
    logic [DW-1:0] env_mem [256];

    always @(posedge clk) begin
        if (init_phase) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
        end else if (ram_we) begin
            env_mem[ram_addr] <= ram_data;
            ram_q             <= ram_data;
        end else begin
            ram_q <= env_mem[ram_addr];
        end
    end

    // ---------------- reference model --------------------------------------
    int            rst_edges = 0;
    always @(posedge rst) rst_edges = rst_edges + 1;

    int            seen_edges = 0;
    int            m_holder;       // -1 none, else requester index
    int            m_run;          // grants in current tenure
    int            m_last;         // last winner
    int            m_pend;         // requester expecting read data this cycle
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] ref_mem [256];

    // Who wins the port given who is asking.
    function automatic int pick(input bit a0, input bit a1);
        if (!a0 && !a1) return -1;
        if (a0 != a1)   return a0 ? 0 : 1;
        if (m_holder < 0)  return 1 - m_last;
        if (m_run < MB)    return m_holder;
        return 1 - m_holder;
    endfunction

    always @(negedge clk) begin : monitor
        int            g;
        bit            exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        if (init_phase) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        end
        if (rst || (rst_edges != seen_edges)) begin
            seen_edges = rst_edges;
            m_holder   = -1;
            m_run      = 0;
            m_last     = 1;
            m_pend     = -1;
        end
        if (rst) begin
            chk("rst_ready0", r0_bus.ready, 0);
            chk("rst_ready1", r1_bus.ready, 0);
            chk("rst_rvalid0", r0_bus.rvalid, 0);
            chk("rst_rvalid1", r1_bus.rvalid, 0);
            chk("rst_ram_we", ram_we, 0);
        end else begin
            chk("rvalid0", r0_bus.rvalid, m_pend == 0);
            chk("rvalid1", r1_bus.rvalid, m_pend == 1);
            if (m_pend == 0) chk("rdata0", r0_bus.rdata, m_pend_data);
            if (m_pend == 1) chk("rdata1", r1_bus.rdata, m_pend_data);

            g = pick(r0_bus.valid, r1_bus.valid);
            exp_we   = 1'b0;
            exp_addr = '0;
            exp_data = '0;
            if (g == 0) begin
                exp_we = r0_bus.we; exp_addr = r0_bus.addr; exp_data = r0_bus.data;
            end else if (g == 1) begin
                exp_we = r1_bus.we; exp_addr = r1_bus.addr; exp_data = r1_bus.data;
            end
            chk("ready0", r0_bus.ready, g == 0);
            chk("ready1", r1_bus.ready, g == 1);
            chk("ram_we", ram_we, exp_we);
            chk("ram_addr", ram_addr, exp_addr);
            chk("ram_data", ram_data, exp_data);

            // Commit the access that happens at the coming edge.
            m_pend = -1;
            if (g >= 0) begin
                if (exp_we) begin
                    ref_mem[exp_addr] = exp_data;
                end else begin
                    m_pend      = g;
                    m_pend_data = ref_mem[exp_addr];
                end
                m_last = g;
                if (g == m_holder) begin
                    m_run = (m_run < MB) ? m_run + 1 : MB;
                end else begin
                    m_holder = g;
                    m_run    = 1;
                end
            end else begin
                m_holder = -1;
                m_run    = 0;
            end
        end
    end

    // ---------------- stimulus ----------------------------------------------
    bit            acc0, acc1, rdy0, rv0, rv1;
    logic [DW-1:0] rd0;

    task automatic step();
        @(negedge clk);
        rdy0 = r0_bus.ready;
        acc0 = r0_bus.valid & r0_bus.ready;
        acc1 = r1_bus.valid & r1_bus.ready;
        rv0  = r0_bus.rvalid;
        rv1  = r1_bus.rvalid;
        rd0  = r0_bus.rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input bit v, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        r0_bus.valid = v; r0_bus.we = w; r0_bus.addr = a; r0_bus.data = d;
    endtask

    task automatic set1(input bit v, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        r1_bus.valid = v; r1_bus.we = w; r1_bus.addr = a; r1_bus.data = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int exp_t2 [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int exp_t3 [4]  = '{0, 0, 1, 1};

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin : main
        int w;
        int prob0, prob1;
        rst        = 1'b1;
        init_phase = 1'b1;
        set1(1'b0, 1'b0, '0, '0);
        set0(1'b1, 1'b0, 8'h00, 8'h00);   // asking during reset must not be granted
        repeat (3) step();
        chk("reset_ready0_held_low", rdy0, 0);
        chk("reset_rvalid0", rv0, 0);
        set0(1'b0, 1'b0, '0, '0);
        init_phase = 1'b0;
        rst        = 1'b0;
        step();

        // T1: r1 writes 0x10, r0 reads it back
        set1(1'b1, 1'b1, 8'h10, 8'hA5);
        step();
        chk("t1_wr_accept_r1", acc1, 1);
        set1(1'b0, 1'b0, '0, '0);
        set0(1'b1, 1'b0, 8'h10, 8'h00);
        step();
        chk("t1_rd_accept_r0", acc0, 1);
        set0(1'b0, 1'b0, '0, '0);
        step();
        chk("t1_rvalid0", rv0, 1);
        chk("t1_rdata0", rd0, 8'hA5);
        chk("t1_rvalid1", rv1, 0);
        step();
        chk("t1_rvalid0_one_cycle", rv0, 0);

        // T2: continuous contention from reset -> bursts of four
        do_reset();
        set0(1'b1, 1'b0, 8'h20, 8'h00);
        set1(1'b1, 1'b0, 8'h21, 8'h00);
        for (int i = 0; i < 12; i++) begin
            step();
            w = acc0 ? 0 : (acc1 ? 1 : 9);
            chk("t2_order", w, exp_t2[i]);
            chk("t2_single_ready", acc0 & acc1, 0);
        end
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        step();

        // T3: r0 drops out after two grants, r1 takes over without a gap
        do_reset();
        set0(1'b1, 1'b0, 8'h30, 8'h00);
        set1(1'b1, 1'b0, 8'h31, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            w = acc0 ? 0 : (acc1 ? 1 : 9);
            chk("t3_order", w, exp_t3[i]);
            if (i == 1) set0(1'b0, 1'b0, '0, '0);
        end
        set1(1'b0, 1'b0, '0, '0);
        step();

        // T4: back-to-back reads 0..7 from r0 alone
        set0(1'b1, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i <= 8; i++) begin
            step();
            if (i < 8) chk("t4_accept", acc0, 1);
            if (i > 0) begin
                chk("t4_rvalid", rv0, 1);
                chk("t4_rdata", rd0, init_val(i - 1));
            end
            if (i < 7) set0(1'b1, 1'b0, AW'(i + 1), 8'h00);
            else       set0(1'b0, 1'b0, '0, '0);
        end

        // T5: reset pulse right after a read accept drops the read
        set0(1'b1, 1'b0, 8'h05, 8'h00);
        step();
        chk("t5_accept", acc0, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_ready_in_rst", r0_bus.ready, 0);
        chk("t5_ram_we_in_rst", ram_we, 0);
        rst = 1'b0;
        set0(1'b0, 1'b0, '0, '0);
        step();
        chk("t5_rvalid_dropped", rv0, 0);
        set0(1'b1, 1'b0, 8'h40, 8'h00);
        set1(1'b1, 1'b0, 8'h41, 8'h00);
        step();
        chk("t5_r0_first", acc0, 1);
        chk("t5_r1_waits", acc1, 0);
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        step();

        // T6: write then read same address from r0
        set0(1'b1, 1'b1, 8'h03, 8'h3C);
        step();
        chk("t6_wr_accept", acc0, 1);
        set0(1'b1, 1'b0, 8'h03, 8'h00);
        step();
        chk("t6_rd_accept", acc0, 1);
        set0(1'b0, 1'b0, '0, '0);
        step();
        chk("t6_rvalid", rv0, 1);
        chk("t6_rdata", rd0, 8'h3C);

        // Randomised traffic; the monitor checks every cycle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            case ((cyc / 500) % 4)
                0:       begin prob0 = 90; prob1 = 90; end
                1:       begin prob0 = 30; prob1 = 95; end
                2:       begin prob0 = 95; prob1 = 20; end
                default: begin prob0 = 60; prob1 = 60; end
            endcase
            if (!r0_bus.valid || acc0)
                set0($urandom_range(0, 99) < prob0, 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
            if (!r1_bus.valid || acc1)
                set1($urandom_range(0, 99) < prob1, 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        set0(1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, '0, '0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
